// File: rtl/alu_seq_exec.sv
// Sequential ALU execute stage: one-cycle ALU ops plus bit-serial shifts
// with valid/ready handshakes on both sides and synchronous flush.
module alu_seq_exec (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  alu_ctrl,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] work_q, work_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  sop_q, sop_d;
  logic [31:0] alu_res;
  logic [31:0] shifted;
  logic        accept;
  logic        is_shift;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;

  // flush in IDLE blocks the accept internally
  assign accept   = in_valid & in_ready & ~flush;
  assign is_shift = (alu_ctrl == 4'b1000) |
                    (alu_ctrl == 4'b1001) |
                    (alu_ctrl == 4'b1010);

  always_comb begin
    alu_res = 32'd0;
    case (alu_ctrl)
      4'b0000: alu_res = op_a + op_b;
      4'b0001: alu_res = op_b;
      4'b0010: alu_res = op_a - op_b;
      4'b0011: alu_res = (op_a + op_b) & ~32'd1;
      4'b0100: alu_res = {31'd0, op_a < op_b};
      4'b0101: alu_res = op_a ^ op_b;
      4'b0110: alu_res = op_a | op_b;
      4'b0111: alu_res = op_a & op_b;
      4'b1100: alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
      default: alu_res = 32'd0;
    endcase
  end

  // sop: 00 sll, 01 sra, 10 srl (low bits of the shift opcode)
  always_comb begin
    shifted = {1'b0, work_q[31:1]};
    unique case (sop_q)
      2'b00:   shifted = {work_q[30:0], 1'b0};
      2'b01:   shifted = {work_q[31], work_q[31:1]};
      default: shifted = {1'b0, work_q[31:1]};
    endcase
  end

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    sop_d    = sop_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = 5'd0;
        if (accept) begin
          if (is_shift) begin
            sop_d = alu_ctrl[1:0];
            if (op_b[4:0] == 5'd0) begin
              result_d = op_a;
              state_d  = DONE;
            end else begin
              work_d  = op_a;
              cnt_d   = op_b[4:0];
              state_d = SHIFT;
            end
          end else begin
            result_d = alu_res;
            state_d  = DONE;
          end
        end
      end
      SHIFT: begin
        if (flush) begin
          cnt_d   = 5'd0;
          state_d = IDLE;
        end else begin
          work_d = shifted;
          cnt_d  = cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            result_d = shifted;
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        if (flush || out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      work_q   <= 32'd0;
      result_q <= 32'd0;
      cnt_q    <= 5'd0;
      sop_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      sop_q    <= sop_d;
    end
  end

endmodule

// File: tb/tb_alu_seq_exec.sv
// Bench for alu_seq_exec: directed scenarios plus random traffic
// checked every cycle against a transaction-level reference model.
module tb_alu_seq_exec;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  alu_seq_exec dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit is_sh(logic [3:0] c);
    return (c == 4'd8) || (c == 4'd9) || (c == 4'd10);
  endfunction

  function automatic logic [31:0] ref_op(logic [3:0] c,
                                         logic [31:0] a,
                                         logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (c)
      4'd0:    return a + b;
      4'd1:    return b;
      4'd2:    return a - b;
      4'd3:    return (a + b) & 32'hFFFF_FFFE;
      4'd4:    return (a < b) ? 32'd1 : 32'd0;
      4'd5:    return a ^ b;
      4'd6:    return a | b;
      4'd7:    return a & b;
      4'd8:    return a << sh;
      4'd9:    return 32'($signed(a) >>> sh);
      4'd10:   return a >> sh;
      4'd12:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // transaction model: busy flag, edges left until result, result value
  logic        m_busy;
  logic        m_done;
  logic [31:0] m_res;
  int          m_rem;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_res  <= 32'd0;
      m_rem  <= 0;
    end else if (!m_busy) begin
      if (in_valid && !flush) begin
        m_busy <= 1'b1;
        m_res  <= ref_op(alu_ctrl, op_a, op_b);
        m_rem  <= is_sh(alu_ctrl) ? int'(op_b[4:0]) : 0;
        m_done <= !is_sh(alu_ctrl) || (op_b[4:0] == 5'd0);
      end
    end else if (flush) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
    end else if (m_done) begin
      if (out_ready) begin
        m_busy <= 1'b0;
        m_done <= 1'b0;
      end
    end else begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) m_done <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 32'(in_ready), 32'(!m_busy));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("out_valid", 32'(out_valid), 32'(m_done));
      if (m_done) chk("result", result, m_res);
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic run_op(string nm, logic [3:0] c, logic [31:0] a,
                        logic [31:0] b, logic [31:0] exp, int lat);
    int n;
    wait_idle();
    in_valid  = 1'b1;
    alu_ctrl  = c;
    op_a      = a;
    op_b      = b;
    out_ready = 1'b1;
    flush     = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    alu_ctrl = 4'($urandom);
    op_a     = $urandom;
    op_b     = $urandom;
    n = 1;
    while (!out_valid && n < 100) begin
      chk({nm, "_busy"}, 32'(busy), 32'd1);
      @(negedge clk);
      n++;
    end
    chk({nm, "_lat"}, 32'(n), 32'(lat));
    chk({nm, "_res"}, result, exp);
  endtask

  initial begin
    int seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    alu_ctrl  = 4'd0;
    op_a      = 32'd0;
    op_b      = 32'd0;
    flush     = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rst_result", result, 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk_en = 1'b1;

    run_op("add_ovf", 4'b0000, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1);
    run_op("sra4", 4'b1001, 32'h8000_0000, 32'h24, 32'hF800_0000, 5);
    run_op("slt", 4'b1100, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
    run_op("sltu", 4'b0100, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
    run_op("sll0", 4'b1000, 32'h1234, 32'h20, 32'h1234, 1);
    run_op("srl31", 4'b1010, 32'h8000_0000, 32'h1F, 32'd1, 32);
    run_op("sub", 4'b0010, 32'd3, 32'd5, 32'hFFFF_FFFE, 1);
    run_op("bad", 4'b1101, 32'd9, 32'd9, 32'd0, 1);

    // backpressure on a jalr result; in_valid held through handoff
    wait_idle();
    in_valid  = 1'b1;
    alu_ctrl  = 4'b0011;
    op_a      = 32'h1000;
    op_b      = 32'h5;
    out_ready = 1'b0;
    @(negedge clk);
    alu_ctrl = 4'b0000;
    op_a     = 32'd1;
    op_b     = 32'd1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_result", result, 32'h1004);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    chk("bp_result4", result, 32'h1004);
    out_ready = 1'b1;
    @(negedge clk);
    chk("hand_valid", 32'(out_valid), 32'd0);
    chk("hand_idle", 32'(busy), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("next_result", result, 32'd2);

    // flush mid sll 31
    wait_idle();
    in_valid = 1'b1;
    alu_ctrl = 4'b1000;
    op_a     = 32'd1;
    op_b     = 32'd31;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    // flush while idle must block the accept
    flush    = 1'b1;
    in_valid = 1'b1;
    alu_ctrl = 4'b0000;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("idle_flush", 32'(busy), 32'd0);
    run_op("add23", 4'b0000, 32'd2, 32'd3, 32'd5, 1);

    // reset in the middle of a shift
    wait_idle();
    in_valid = 1'b1;
    alu_ctrl = 4'b1001;
    op_a     = 32'h8000_0000;
    op_b     = 32'd20;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_result", result, 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("mrst_stale", 32'(seen), 32'd0);

    // random traffic
    repeat (500) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 2) != 0);
      alu_ctrl  = 4'($urandom);
      case ($urandom_range(0, 5))
        0:       op_a = 32'd0;
        1:       op_a = 32'h7FFF_FFFF;
        2:       op_a = 32'h8000_0000;
        3:       op_a = 32'hFFFF_FFFF;
        default: op_a = $urandom;
      endcase
      op_b      = ($urandom_range(0, 3) == 0) ? 32'(op_a) : $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (40) @(negedge clk);
    chk("drain_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
